// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (core / debug) arbiter in front of a single-port data
//            memory with 1-cycle read latency and starvation guard for debug.
//            Optional conflict counter enabled by defining DMEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_W-1:0]     c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  input  logic [DATA_W/8-1:0]   c_wstrb,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_W-1:0]     c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  core_stall,
  output logic [15:0]           conflict_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e              owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic [DATA_W-1:0]   c_hold_q, c_hold_d;
  logic [DATA_W-1:0]   d_hold_q, d_hold_d;
  logic                w_d_prio;

  always_comb begin
    w_d_prio   = (starve_q >= STARVE_LIM);
    c_gnt      = ~rst & c_req & ~(d_req & w_d_prio);
    d_gnt      = ~rst & d_req & (~c_req | w_d_prio);
    core_stall = c_req & ~c_gnt;

    mem_en    = c_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_wstrb = c_wstrb;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end
  end

  // rvalid comes from the registered owner tag; rdata passes mem_rdata through
  // in the return cycle and otherwise replays the value captured at that edge.
  always_comb begin
    c_rvalid = (owner_q == OWN_C) & ~rst;
    d_rvalid = (owner_q == OWN_D) & ~rst;
    c_rdata  = c_rvalid ? mem_rdata : c_hold_q;
    d_rdata  = d_rvalid ? mem_rdata : d_hold_q;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (c_gnt && !c_we) begin
      owner_d = OWN_C;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end

    starve_d = 4'd0;
    if (d_req && !d_gnt) begin
      starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
    end

    c_hold_d = c_rdata;
    d_hold_d = d_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      c_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      c_hold_q <= c_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (c_req && d_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 16'h0000;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Table-driven bench for dmem_arbiter with a read-return scoreboard
//            and a behavioural single-port memory behind the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_wstrb, d_wstrb;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        core_stall;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .core_stall(core_stall), .conflict_cnt(conflict_cnt)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Behavioural memory: loaded once, not cleared by rst, so a write leaking
  // out of a reset cycle would be visible later.
  logic [31:0] mem [0:63];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (rst) mem_rdata <= 32'h0;
    else if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [31:0] ca, cwd;
    logic [3:0]  cs;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic [3:0]  ds;
    logic        ec, ed;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } ret_t;

  logic [31:0] ref_mem [0:63];
  ret_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          conf_exp = 0;
  logic [31:0] c_last = 32'h0;
  logic [31:0] d_last = 32'h0;
  vec_t        tbl [15];

  function automatic vec_t mk(input logic r,
                              input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cwd, input logic [3:0] cs,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dwd, input logic [3:0] ds,
                              input logic ec, input logic ed);
    vec_t v;
    v.rst = r;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cwd = cwd; v.cs = cs;
    v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ds = ds;
    v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    ret_t e;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      e.is_d = is_d;
      e.data = ref_mem[addr[7:2]];
      sb.push_back(e);
    end
  endtask

  task automatic step(input vec_t v);
    ret_t        e;
    logic [15:0] conf_want;
    rst = v.rst;
    c_req = v.cr; c_we = v.cw; c_addr = v.ca; c_wdata = v.cwd; c_wstrb = v.cs;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd; d_wstrb = v.ds;
    @(negedge clk);
    if (v.rst) begin
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      sb.delete();
      c_last = 32'h0;
      d_last = 32'h0;
      conf_exp = 0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_d) begin
          chk("d_rvalid", d_rvalid, 1);
          chk("d_rdata", d_rdata, e.data);
          chk("c_rvalid_quiet", c_rvalid, 0);
          chk("c_rdata_hold", c_rdata, c_last);
          d_last = e.data;
        end else begin
          chk("c_rvalid", c_rvalid, 1);
          chk("c_rdata", c_rdata, e.data);
          chk("d_rvalid_quiet", d_rvalid, 0);
          chk("d_rdata_hold", d_rdata, d_last);
          c_last = e.data;
        end
      end else begin
        chk("c_rvalid_idle", c_rvalid, 0);
        chk("d_rvalid_idle", d_rvalid, 0);
        chk("c_rdata_hold", c_rdata, c_last);
        chk("d_rdata_hold", d_rdata, d_last);
      end
      chk("c_gnt", c_gnt, v.ec);
      chk("d_gnt", d_gnt, v.ed);
      chk("core_stall", core_stall, v.cr & ~v.ec);
      chk("mem_en", mem_en, v.ec | v.ed);
      if (v.ec) begin
        chk("mem_addr_c", mem_addr, v.ca);
        chk("mem_we_c", mem_we, v.cw);
        issue(1'b0, v.cw, v.ca, v.cwd, v.cs);
      end else if (v.ed) begin
        chk("mem_addr_d", mem_addr, v.da);
        chk("mem_we_d", mem_we, v.dw);
        issue(1'b1, v.dw, v.da, v.dwd, v.ds);
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_wstrb_idle", mem_wstrb, 0);
      end
`ifdef DMEM_ARB_PERF_EN
      conf_want = 16'(conf_exp);
`else
      conf_want = 16'h0;
`endif
      chk("conflict_cnt", conflict_cnt, conf_want);
      if (v.cr && v.dr) conf_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle_v;
    logic [15:0] perf_want;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    idle_v = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0);
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    @(posedge clk);
    #1;
    step(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    step(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));

    tbl[0]  = idle_v;
    tbl[1]  = mk(0, 1,0,32'h10,0,0,            0,0,0,0,0,                      1,0);
    tbl[2]  = idle_v;
    tbl[3]  = mk(0, 0,0,0,0,0,                 1,1,32'h20,32'h12345678,4'hF,   0,1);
    tbl[4]  = mk(0, 1,0,32'h20,0,0,            0,0,0,0,0,                      1,0);
    tbl[5]  = idle_v;
    tbl[6]  = mk(0, 1,0,32'h0,0,0,             0,0,0,0,0,                      1,0);
    tbl[7]  = mk(0, 0,0,0,0,0,                 1,0,32'h4,0,0,                  0,1);
    tbl[8]  = idle_v;
    tbl[9]  = mk(0, 1,1,32'h8,32'hCAFEF00D,4'h3, 0,0,0,0,0,                    1,0);
    tbl[10] = mk(0, 0,0,0,0,0,                 1,0,32'h8,0,0,                  0,1);
    tbl[11] = idle_v;
    tbl[12] = mk(0, 1,0,32'h10,0,0,            1,0,32'h14,0,0,                 1,0);
    tbl[13] = mk(0, 0,0,0,0,0,                 1,0,32'h14,0,0,                 0,1);
    tbl[14] = idle_v;
    for (int i = 0; i < 15; i++) step(tbl[i]);
    chk("partial_write_word", ref_mem[2], 32'hA500_F00D);

    // Sustained contention: debug wins exactly once after four denials.
    for (int k = 0; k < 9; k++)
      step(mk(0, 1,0,32'h10,0,0, 1,0,32'h14,0,0, (k != 4), (k == 4)));
    step(idle_v);

    // Build up starvation, reset mid-read with a write pending in the reset cycle.
    for (int k = 0; k < 3; k++)
      step(mk(0, 1,0,32'h0,0,0, 1,0,32'h4,0,0, 1,0));
    step(mk(1, 1,1,32'h0,32'hFFFFFFFF,4'hF, 1,0,32'h4,0,0, 0,0));

    // Fresh contention after reset: starvation count must restart from zero.
    for (int k = 0; k < 10; k++)
      step(mk(0, 1,0,32'h0,0,0, 1,0,32'h4,0,0, (k != 4 && k != 9), (k == 4 || k == 9)));
    step(idle_v);
`ifdef DMEM_ARB_PERF_EN
    perf_want = 16'd10;
`else
    perf_want = 16'd0;
`endif
    chk("perf_conflict_10", conflict_cnt, perf_want);
    chk("rst_write_dropped", mem[0], 32'hA500_0000);
    step(idle_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
